datapath_unit: RTL and testbench

- Register/ALU datapath driven by the microprocessor control FSM.
- Consumes the FSM control word (clear, per-register clock enables, write-bus select, operand select, ALU op) one word per clock.
- Executes register transfers and ALU operations, and returns condition flags to the controller.
- Sits directly downstream of fsm, the receiving end of the control interface.

---
 rtl/datapath_unit.sv | 151 +++++++++++++++
 tb/tb_datapath_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_unit.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_unit
//  Description : Four-register / ALU datapath driven by the controller's
//                control word. It performs one register transfer or ALU
//                operation per clock and returns zero/carry condition flags.
//  Ports       :
//      clk      - system clock; all state updates on the rising edge
//      reset    - asynchronous active-low reset
//      clr_i    - synchronous clear of all registers and both flags
//      ce_i     - per-register load enables; bit k loads R[k]
//      w_i      - write-bus source select
//      sel_i    - ALU operand B select, B = R[sel_i]
//      s_i      - ALU operation select
//      data_i   - external load data
//      regs_o   - {R3,R2,R1,R0}, registered
//      alu_o    - combinational ALU result
//      zero_o   - registered zero flag
//      carry_o  - registered carry/borrow flag
//  Revision    : 1.0  initial release
// ============================================================================
module datapath_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic [3:0]           ce_i,
    input  logic [2:0]           w_i,
    input  logic [1:0]           sel_i,
    input  logic [2:0]           s_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [4*WIDTH-1:0]   regs_o,
    output logic [WIDTH-1:0]     alu_o,
    output logic                 zero_o,
    output logic                 carry_o
);

    logic [WIDTH-1:0] r_regs [4];
    logic             r_zero;
    logic             r_carry;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu;
    logic             w_carry;
    logic [WIDTH-1:0] w_bus;
    logic             w_flag_upd;

    // R0 is the fixed accumulator; operand B is any register.
    assign w_a = r_regs[0];
    assign w_b = r_regs[sel_i];

    // The extra top bit of the widened difference is set exactly when A < B,
    // which gives the borrow directly.
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_alu   = w_a;
        w_carry = 1'b0;
        case (s_i)
            3'b000: w_alu = w_a;
            3'b001: begin
                w_alu   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            3'b010: begin
                w_alu   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            3'b011: w_alu = w_a & w_b;
            3'b100: w_alu = w_a | w_b;
            3'b101: w_alu = w_a ^ w_b;
            3'b110: w_alu = ~w_a;
            3'b111: begin
                w_alu   = {w_a[WIDTH-2:0], 1'b0};
                w_carry = w_a[WIDTH-1];
            end
            default: begin
                w_alu   = w_a;
                w_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_bus = data_i;
        case (w_i)
            3'b000:  w_bus = data_i;
            3'b001:  w_bus = w_alu;
            3'b010:  w_bus = r_regs[0];
            3'b011:  w_bus = r_regs[1];
            3'b100:  w_bus = r_regs[2];
            3'b101:  w_bus = r_regs[3];
            3'b110:  w_bus = '0;
            3'b111:  w_bus = '1;
            default: w_bus = data_i;
        endcase
    end

    // Flags only track ALU results that are actually written somewhere.
    assign w_flag_upd = (w_i == 3'b001) && (ce_i != 4'b0000);

    // All registers sample the pre-edge write bus, so R0 <= R0 op R[n]
    // accumulates correctly and multi-enable loads see the same value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                r_regs[k] <= '0;
            end
        end else if (clr_i) begin
            for (int k = 0; k < 4; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ce_i[k]) begin
                    r_regs[k] <= w_bus;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (clr_i) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_flag_upd) begin
            r_zero  <= (w_alu == '0);
            r_carry <= w_carry;
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_pack
            assign regs_o[g*WIDTH +: WIDTH] = r_regs[g];
        end
    endgenerate

    assign alu_o   = w_alu;
    assign zero_o  = r_zero;
    assign carry_o = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_datapath_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_unit
//  Description : Scoreboard bench for datapath_unit. A driver applies control
//                words, evaluates an arithmetic reference model and queues the
//                expected outputs; a monitor pops and compares every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_datapath_unit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             clr_i;
    logic [3:0]       ce_i;
    logic [2:0]       w_i;
    logic [1:0]       sel_i;
    logic [2:0]       s_i;
    logic [WIDTH-1:0] data_i;
    logic [4*WIDTH-1:0] regs_o;
    logic [WIDTH-1:0] alu_o;
    logic             zero_o;
    logic             carry_o;

    datapath_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_i),
        .ce_i    (ce_i),
        .w_i     (w_i),
        .sel_i   (sel_i),
        .s_i     (s_i),
        .data_i  (data_i),
        .regs_o  (regs_o),
        .alu_o   (alu_o),
        .zero_o  (zero_o),
        .carry_o (carry_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] regs;
        logic [7:0]  alu;
        logic        z;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: plain integers, one per register.
    int m_r [4];
    bit m_z;
    bit m_c;

    function automatic logic [31:0] pack_regs();
        return {m_r[3][7:0], m_r[2][7:0], m_r[1][7:0], m_r[0][7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("regs",  regs_o,  e.regs);
            check("alu",   {24'd0, alu_o}, {24'd0, e.alu});
            check("zero",  {31'd0, zero_o},  {31'd0, e.z});
            check("carry", {31'd0, carry_o}, {31'd0, e.c});
        end
    end

    // Called right after an active edge: drive a control word, queue what the
    // outputs must show this cycle, advance the model across the next edge.
    task automatic step(input bit clr, input int ce, input int w, input int sel,
                        input int s, input int data);
        int a, b, res, bus;
        bit cy;
        exp_t e;
        clr_i = clr; ce_i = ce[3:0]; w_i = w[2:0]; sel_i = sel[1:0];
        s_i = s[2:0]; data_i = data[7:0];

        a = m_r[0];
        b = m_r[sel & 3];
        cy = 1'b0;
        case (s & 7)
            0: res = a;
            1: begin res = (a + b) % 256; cy = (a + b) > 255; end
            2: begin res = (a - b + 256) % 256; cy = a < b; end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = 255 - a;
            default: begin res = (a * 2) % 256; cy = a >= 128; end
        endcase
        case (w & 7)
            0: bus = data & 255;
            1: bus = res;
            2, 3, 4, 5: bus = m_r[(w & 7) - 2];
            6: bus = 0;
            default: bus = 255;
        endcase

        e.regs = pack_regs();
        e.alu  = res[7:0];
        e.z    = m_z;
        e.c    = m_c;
        q.push_back(e);

        if (clr) begin
            for (int k = 0; k < 4; k++) m_r[k] = 0;
            m_z = 0; m_c = 0;
        end else begin
            for (int k = 0; k < 4; k++) if (ce[k]) m_r[k] = bus;
            if ((w & 7) == 1 && (ce & 15) != 0) begin
                m_z = (res == 0);
                m_c = cy;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_r[k] = 0;
        m_z = 0; m_c = 0;
    endtask

    initial begin
        reset = 1'b0; clr_i = 0; ce_i = 0; w_i = 0; sel_i = 0; s_i = 0; data_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        step(0, 0, 0, 0, 0, 0);

        // Load / add
        step(0, 4'b0001, 0, 0, 0, 8'h05);
        step(0, 4'b0010, 0, 0, 0, 8'h03);
        step(0, 4'b0100, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check("add_r2", regs_o[23:16], 32'h08);

        // Subtract with borrow
        step(0, 4'b0001, 0, 0, 0, 8'h03);
        step(0, 4'b0010, 0, 0, 0, 8'h05);
        step(0, 4'b1000, 1, 1, 2, 0);
        step(0, 0, 0, 0, 0, 0);
        check("sub_r3", regs_o[31:24], 32'hFE);
        check("sub_carry", {31'd0, carry_o}, 32'd1);

        // Add wrap, then a non-ALU load must leave flags alone
        step(0, 4'b0001, 0, 0, 0, 8'hFF);
        step(0, 4'b0010, 0, 0, 0, 8'h01);
        step(0, 4'b0001, 1, 1, 1, 0);
        step(0, 4'b0010, 0, 0, 0, 8'h33);
        step(0, 0, 0, 0, 0, 0);
        check("wrap_zero", {31'd0, zero_o}, 32'd1);
        check("wrap_carry", {31'd0, carry_o}, 32'd1);

        // Move with multiple enables, then clear overriding a load
        step(0, 4'b0100, 0, 0, 0, 8'h5A);
        step(0, 4'b1011, 4, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("move_all", regs_o, 32'h5A5A5A5A);
        step(1, 4'b1111, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("clear", regs_o, 32'h0);

        // Shift / logic sweep on R0=81, R1=0F
        step(0, 4'b0001, 0, 0, 0, 8'h81);
        step(0, 4'b0010, 0, 0, 0, 8'h0F);
        for (int s = 0; s < 8; s++) step(0, 4'b0100, 1, 1, s, 0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 7), $urandom_range(0, 255));
        end

        // Make sure something is loaded, then reset mid-cycle with a load pending
        step(0, 4'b1111, 7, 0, 0, 0);
        ce_i = 4'b1111; w_i = 3'b000; data_i = 8'hAA; clr_i = 0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_regs", regs_o, 32'h0);
        check("rst_flags", {30'd0, zero_o, carry_o}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold", regs_o, 32'h0);
        ce_i = 4'b0000;
        reset = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 3, 0);

        for (int n = 0; n < 100; n++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 15),
                 $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 7), $urandom_range(0, 255));
        end

        // Bounded drain of the scoreboard
        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        check("drain", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
